// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
// Used by pc_gen and pc_next_sel.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4,
    PC_SRC_TARGET,
    PC_SRC_ALU,
    PC_SRC_EPC
  } pc_src_e;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_HALT
  } pc_state_e;

  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_gen_next_sel.sv
// Combinational next-PC selection with target-alignment detection.
// Trap substitution is left to the caller so the mux stays a pure selector.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  pc_src_e          src,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  target,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  epc,
  output logic [XLEN-1:0]  next_pc,
  output logic             misaligned
);

  logic [XLEN-1:0] jalr_tgt;

  // jalr clears bit0 before the alignment test, so only bit1 can still trap.
  assign jalr_tgt = alu_result & ~XLEN'(1);

  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    case (src)
      PC_SRC_TARGET: begin
        next_pc    = target;
        misaligned = |target[1:0];
      end
      PC_SRC_ALU: begin
        next_pc    = jalr_tgt;
        misaligned = |jalr_tgt[1:0];
      end
      PC_SRC_EPC:   next_pc = epc;
      default:      next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter with BOOT/RUN/HALT control, stall hold and misaligned-target trap.
// Optional redirect counter enabled by defining PC_GEN_REDIRECT_CNT_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Halt,
  input  logic [1:0]       PCSrc,
  input  logic [XLEN-1:0]  PCTarget,
  input  logic [XLEN-1:0]  ALUResult,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PCPlus4,
  output logic             FetchValid,
  output logic [XLEN-1:0]  EPC,
  output logic             TrapPulse,
`ifdef PC_GEN_REDIRECT_CNT_EN
  output logic [31:0]      RedirectCount,
`endif
  output logic             Halted
);

  pc_state_e       state, state_d;
  pc_src_e         src;
  logic [XLEN-1:0] sel_pc, pc_d, epc_d;
  logic            misaligned, trap_d, redirect;

  assign src        = pc_src_e'(PCSrc);
  assign PCPlus4    = PC + XLEN'(PC_INC);
  assign FetchValid = (state == PC_RUN);
  assign Halted     = (state == PC_HALT);

  pc_next_sel #(.XLEN(XLEN)) u_sel (
    .src        (src),
    .pc_plus4   (PCPlus4),
    .target     (PCTarget),
    .alu_result (ALUResult),
    .epc        (EPC),
    .next_pc    (sel_pc),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d  = state;
    pc_d     = PC;
    epc_d    = EPC;
    trap_d   = 1'b0;
    redirect = 1'b0;
    case (state)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN: begin
        if (Halt) begin
          state_d = PC_HALT;
        end else if (!Stall) begin
          redirect = (src != PC_SRC_PLUS4);
          if (misaligned) begin
            pc_d   = TRAP_VECTOR;
            epc_d  = PC;
            trap_d = 1'b1;
          end else begin
            pc_d = sel_pc;
          end
        end
      end
      default: state_d = state;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= PC_BOOT;
      PC        <= RESET_VECTOR;
      EPC       <= '0;
      TrapPulse <= 1'b0;
    end else begin
      state     <= state_d;
      PC        <= pc_d;
      EPC       <= epc_d;
      TrapPulse <= trap_d;
    end
  end

`ifdef PC_GEN_REDIRECT_CNT_EN
  always_ff @(posedge CLK) begin
    if (Reset)
      RedirectCount <= '0;
    else if (redirect && (RedirectCount != 32'hFFFF_FFFF))
      RedirectCount <= RedirectCount + 32'd1;
  end
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: 32-bit instance plus an 8-bit wrap instance.
module tb_pc_gen;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset, Stall, Halt;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget, ALUResult;
  logic [31:0] PC, PCPlus4, EPC;
  logic        FetchValid, TrapPulse, Halted;

  logic        R8, S8, H8;
  logic [1:0]  Src8;
  logic [7:0]  Tgt8, Alu8;
  logic [7:0]  PC8, PCPlus48, EPC8;
  logic        FV8, TP8, HL8;

`ifdef PC_GEN_REDIRECT_CNT_EN
  logic [31:0] RedirectCount, RC8;
`endif

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)) dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Halt(Halt), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .ALUResult(ALUResult), .PC(PC), .PCPlus4(PCPlus4),
    .FetchValid(FetchValid), .EPC(EPC), .TrapPulse(TrapPulse),
`ifdef PC_GEN_REDIRECT_CNT_EN
    .RedirectCount(RedirectCount),
`endif
    .Halted(Halted)
  );

  pc_gen #(.XLEN(8), .RESET_VECTOR(8'h0), .TRAP_VECTOR(8'h80)) dut8 (
    .CLK(CLK), .Reset(R8), .Stall(S8), .Halt(H8), .PCSrc(Src8),
    .PCTarget(Tgt8), .ALUResult(Alu8), .PC(PC8), .PCPlus4(PCPlus48),
    .FetchValid(FV8), .EPC(EPC8), .TrapPulse(TP8),
`ifdef PC_GEN_REDIRECT_CNT_EN
    .RedirectCount(RC8),
`endif
    .Halted(HL8)
  );

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        hl;
    logic        tp;
    logic [31:0] epc;
    logic [31:0] rc;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;
  logic [31:0] exp_rc = 0;
  logic        prev_fv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL step%0d %s observed=%h expected=%h", n, tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst, input logic stall, input logic halt, input logic [1:0] src,
                      input logic [31:0] tgt, input logic [31:0] alu,
                      input logic [31:0] e_pc, input logic e_fv, input logic e_hl,
                      input logic e_tp, input logic [31:0] e_epc);
    exp_t e, o;
    Reset = rst; Stall = stall; Halt = halt; PCSrc = src; PCTarget = tgt; ALUResult = alu;
    if (rst)
      exp_rc = 0;
    else if (prev_fv && !stall && !halt && src != 2'b00 && exp_rc != 32'hFFFF_FFFF)
      exp_rc = exp_rc + 1;
    prev_fv = rst ? 1'b0 : e_fv;
    e.pc = e_pc; e.fv = e_fv; e.hl = e_hl; e.tp = e_tp; e.epc = e_epc; e.rc = exp_rc;
    q.push_back(e);
    @(posedge CLK);
    #1;
    n++;
    o = q.pop_front();
    chk("PC", PC, o.pc);
    chk("PCPlus4", PCPlus4, o.pc + 32'd4);
    chk("FetchValid", {31'b0, FetchValid}, {31'b0, o.fv});
    chk("Halted", {31'b0, Halted}, {31'b0, o.hl});
    chk("TrapPulse", {31'b0, TrapPulse}, {31'b0, o.tp});
    chk("EPC", EPC, o.epc);
`ifdef PC_GEN_REDIRECT_CNT_EN
    chk("RedirectCount", RedirectCount, o.rc);
`endif
  endtask

  task automatic step8(input logic rst, input logic [1:0] src, input logic [7:0] tgt,
                       input logic [7:0] e_pc, input logic e_fv, input logic e_tp,
                       input logic [7:0] e_epc);
    exp_t e, o;
    logic [7:0] p4;
    R8 = rst; S8 = 1'b0; H8 = 1'b0; Src8 = src; Tgt8 = tgt; Alu8 = 8'h0;
    e.pc = {24'b0, e_pc}; e.fv = e_fv; e.hl = 1'b0; e.tp = e_tp; e.epc = {24'b0, e_epc}; e.rc = 0;
    q8.push_back(e);
    @(posedge CLK);
    #1;
    n++;
    o = q8.pop_front();
    p4 = o.pc[7:0] + 8'd4;
    chk("PC8", {24'b0, PC8}, o.pc);
    chk("PCPlus4_8", {24'b0, PCPlus48}, {24'b0, p4});
    chk("FetchValid8", {31'b0, FV8}, {31'b0, o.fv});
    chk("TrapPulse8", {31'b0, TP8}, {31'b0, o.tp});
    chk("EPC8", {24'b0, EPC8}, o.epc);
  endtask

  initial begin
    R8 = 1'b1; S8 = 1'b0; H8 = 1'b0; Src8 = 2'b00; Tgt8 = 8'h0; Alu8 = 8'h0;
    // reset, BOOT ignores Stall/Halt/redirects, then sequential fetch
    step(1, 0, 0, 2'b00, 0, 0,        32'h0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 2'b01, 32'h3, 0,    32'h0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 2'b00, 0, 0,        32'h4, 1, 0, 0, 32'h0);
    step(0, 0, 0, 2'b00, 0, 0,        32'h8, 1, 0, 0, 32'h0);
    step(0, 0, 0, 2'b00, 0, 0,        32'hC, 1, 0, 0, 32'h0);
    step(0, 0, 0, 2'b00, 0, 0,        32'h10, 1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 2'b00, 0, 0,      32'h14 + 32'(4 * i), 1, 0, 0, 32'h0);
    // branch, jalr with bit0 cleared, misaligned trap, return
    step(0, 0, 0, 2'b01, 32'h80, 0,   32'h80, 1, 0, 0, 32'h0);
    step(0, 0, 0, 2'b10, 0, 32'h41,   32'h40, 1, 0, 0, 32'h0);
    step(0, 0, 0, 2'b01, 32'h86, 0,   32'h100, 1, 0, 1, 32'h40);
    step(0, 0, 0, 2'b11, 0, 0,        32'h40, 1, 0, 0, 32'h40);
    step(0, 0, 0, 2'b01, 32'h10, 0,   32'h10, 1, 0, 0, 32'h40);
    // stall suppresses a misaligned redirect
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 2'b01, 32'h3, 0,  32'h10, 1, 0, 0, 32'h40);
    step(0, 0, 0, 2'b00, 0, 0,        32'h14, 1, 0, 0, 32'h40);
    // jalr misaligned in bit1, then back-to-back trap overwriting EPC
    step(0, 0, 0, 2'b10, 0, 32'h16,   32'h100, 1, 0, 1, 32'h14);
    step(0, 0, 0, 2'b01, 32'h6, 0,    32'h100, 1, 0, 1, 32'h100);
    step(0, 0, 0, 2'b11, 0, 0,        32'h100, 1, 0, 0, 32'h100);
    step(0, 0, 0, 2'b01, 32'h14, 0,   32'h14, 1, 0, 0, 32'h100);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 2'b00, 0, 0,      32'h18 + 32'(4 * i), 1, 0, 0, 32'h100);
    // HALT freezes everything until reset
    step(0, 0, 1, 2'b01, 32'h86, 0,   32'h24, 0, 1, 0, 32'h100);
    for (int i = 0; i < 10; i++)
      step(0, i[0], i[1], 2'(i), 32'h86, 32'h43, 32'h24, 0, 1, 0, 32'h100);
    step(1, 0, 1, 2'b01, 32'h86, 0,   32'h0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 2'b00, 0, 0,        32'h0, 1, 0, 0, 32'h0);
    // three taken redirects and one stalled redirect
    step(0, 0, 0, 2'b01, 32'h8, 0,    32'h8, 1, 0, 0, 32'h0);
    step(0, 0, 0, 2'b10, 0, 32'h21,   32'h20, 1, 0, 0, 32'h0);
    step(0, 1, 0, 2'b01, 32'h40, 0,   32'h20, 1, 0, 0, 32'h0);
    step(0, 0, 0, 2'b11, 0, 0,        32'h0, 1, 0, 0, 32'h0);
`ifdef PC_GEN_REDIRECT_CNT_EN
    chk("RedirectCount_final", RedirectCount, 32'd3);
`endif
    // 8-bit instance: PC wraps modulo 2^8
    step8(1, 2'b00, 8'h0,  8'h00, 0, 0, 8'h00);
    step8(0, 2'b00, 8'h0,  8'h00, 1, 0, 8'h00);
    step8(0, 2'b01, 8'hFC, 8'hFC, 1, 0, 8'h00);
    step8(0, 2'b00, 8'h0,  8'h00, 1, 0, 8'h00);
    step8(0, 2'b01, 8'h02, 8'h80, 1, 1, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter for the single-cycle/multi-cycle RV32I core. Sits at the front of fetch and drives instruction-memory address.
- Adds configurable width and vectors, a stall hold, a halt state, a boot cycle, and misaligned-target trap with EPC save/return.
- Replaces the fixed 32-bit, 3-way next-PC selector.

Parameters:
- XLEN, 32, PC/datapath width in bits (≥ 8).
- RESET_VECTOR, 'h0, PC value loaded by reset.
- TRAP_VECTOR, 'h100, PC value loaded on misaligned-target trap (must be 4-byte aligned).

Ports:
- CLK  in  1  core clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold PC this cycle (hazard/memory wait).
- Halt  in  1  enter HALT state (ebreak/ecall-halt decode).
- PCSrc  in  2  00 PCPlus4, 01 PCTarget, 10 ALUResult (jalr), 11 return-from-trap (EPC).
- PCTarget  in  XLEN  branch/jal target.
- ALUResult  in  XLEN  jalr target.
- PC  out  XLEN  current PC.
- PCPlus4  out  XLEN  PC + 4, modulo 2^XLEN.
- FetchValid  out  1  PC is a valid fetch address this cycle.
- EPC  out  XLEN  PC of the instruction whose target trapped.
- TrapPulse  out  1  one-cycle strobe, trap taken at this edge.
- Halted  out  1  high while in HALT.

Behaviour:
- Reset is synchronous and active-high, clocked on CLK. On Reset at a rising edge:
  - PC = RESET_VECTOR, EPC = 0, TrapPulse = 0, state = BOOT.
  - Reset has priority over every other input, including mid-stall, mid-trap and HALT.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle. PC holds RESET_VECTOR, FetchValid = 0, Halted = 0.
  - Next state is always RUN; Stall and Halt are ignored.
- RUN:
  - FetchValid = 1.
  - Per-edge priority: Halt > Stall > PCSrc.
  - Halt = 1: next state HALT; PC unchanged.
  - Stall = 1 (Halt = 0): PC, EPC and state held; no trap raised even if the target is misaligned.
  - PCSrc = 00: PC <= PC + 4; wraps at 2^XLEN.
  - PCSrc = 01: candidate = PCTarget.
  - PCSrc = 10: candidate = ALUResult with bit0 forced to 0 (jalr semantics).
  - PCSrc = 11: PC <= EPC, no alignment check.
  - For 01/10, if candidate[1:0] != 0:
    - PC <= TRAP_VECTOR, EPC <= current PC.
    - TrapPulse = 1 for the cycle following the edge.
    - Otherwise PC <= candidate.
  - A trap while already in the trap handler overwrites EPC; no nesting.
- HALT:
  - PC frozen, FetchValid = 0, Halted = 1.
  - All inputs except Reset are ignored; the only exit is Reset.
- Output timing:
  - PCPlus4 is combinational from PC.
  - All other outputs are registered or state-decoded; there are no combinational input-to-output paths.
- TrapPulse is never high for two consecutive cycles unless two consecutive trapping redirects occur.

Optional Feature:
- Macro: PC_GEN_REDIRECT_CNT_EN.
- Defined:
  - Adds output RedirectCount [31:0], cleared by Reset.
  - Increments by 1 on each RUN edge with Stall = 0, Halt = 0 and PCSrc != 00, trapped redirects included.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - typedef enum logic [1:0] pc_src_e {PC_SRC_PLUS4, PC_SRC_TARGET, PC_SRC_ALU, PC_SRC_EPC}.
  - typedef enum logic [1:0] pc_state_e {PC_BOOT, PC_RUN, PC_HALT}.
  - localparam PC_INC = 4.
- Single module. The next-PC mux plus the alignment check is a natural sub-module, pc_next_sel (combinational). The state register, PC, EPC and counter stay in pc_gen.

Test Plan:
- Reset, then release: cycle 0 PC = 0, FetchValid = 0 (BOOT); cycle 1 PC = 0, FetchValid = 1; cycle 2 PC = 4; after 3 more cycles PC = 'h10.
- At PC = 'h20: PCSrc = 01, PCTarget = 'h80 -> PC = 'h80. Then PCSrc = 10, ALUResult = 'h41 -> PC = 'h40 (bit0 cleared), no trap.
- At PC = 'h40: PCSrc = 01, PCTarget = 'h86 -> PC = 'h100, EPC = 'h40, TrapPulse = 1 for one cycle. Then PCSrc = 11 -> PC = 'h40.
- At PC = 'h10: Stall = 1 for 3 cycles with PCSrc = 01, PCTarget = 'h3 -> PC stays 'h10, TrapPulse = 0, EPC unchanged. Release with PCSrc = 00 -> PC = 'h14.
- Halt = 1 at PC = 'h24 -> Halted = 1, FetchValid = 0, PC = 'h24 held for 10 cycles despite PCSrc toggling. Reset -> PC = 0, BOOT.
- XLEN = 8, PC = 'hFC, PCSrc = 00 -> PC = 'h00 (wrap). With PC_GEN_REDIRECT_CNT_EN: 3 taken redirects plus 1 stalled redirect -> RedirectCount = 3.
